// File: rtl/state_sequencer_if.sv
// state_sequencer_if: control and status bundle between a host and state_sequencer
interface state_sequencer_if;
  logic       start;
  logic [2:0] mode;
  logic       step_done;
  logic       abort;
  logic       clear;
  logic [3:0] current_state;
  logic [2:0] selector;
  logic [3:0] step_cnt;
  logic       busy;
  logic       done;
  logic       err;
  modport master(
    output start, mode, step_done, abort, clear,
    input  current_state, selector, step_cnt, busy, done, err
  );
  modport slave(
    input  start, mode, step_done, abort, clear,
    output current_state, selector, step_cnt, busy, done, err
  );
endinterface

// File: rtl/state_sequencer.sv
// state_sequencer: IDLE/LOAD/RUN/DONE step sequencer; SEQ_TIMEOUT_EN adds a RUN stall timeout into ERROR
module state_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int TIMEOUT   = 255
) (
  input logic              clk,
  input logic              rst_n,
  state_sequencer_if.slave bus
);
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LOAD  = 4'd1;
  localparam logic [3:0] RUN   = 4'd2;
  localparam logic [3:0] DONE  = 4'd3;
  localparam logic [3:0] ERROR = 4'd15;
  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [2:0] r_sel;
  logic [3:0] r_cnt;
  logic       w_last;
  logic       w_tmo;
  assign w_last = r_cnt == 4'(NUM_STEPS - 1);
`ifdef SEQ_TIMEOUT_EN
  logic [7:0] r_idle;
  assign w_tmo = r_idle == 8'(TIMEOUT - 1);
  // idle-cycle counter: cleared in LOAD and on each step, saturating count of stalled RUN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idle <= 8'd0;
    else if (r_state == LOAD || (r_state == RUN && bus.step_done)) r_idle <= 8'd0;
    else if (r_state == RUN && r_idle != 8'hFF) r_idle <= r_idle + 8'd1;
  end
`else
  logic w_unused;
  assign w_tmo    = 1'b0;
  assign w_unused = bus.clear | (TIMEOUT == 0);
`endif
  // next-state decode; abort outranks step_done and timeout, unknown codes fall back to IDLE
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = bus.start ? LOAD : IDLE;
      LOAD:    w_next = bus.abort ? IDLE : RUN;
      RUN:     w_next = bus.abort ? IDLE : bus.step_done ? (w_last ? DONE : RUN) : w_tmo ? ERROR : RUN;
      DONE:    w_next = IDLE;
`ifdef SEQ_TIMEOUT_EN
      ERROR:   w_next = bus.clear ? IDLE : ERROR;
`endif
      default: w_next = IDLE;
    endcase
  end
  // state, latched mode and step count; count holds through IDLE until the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_sel <= bus.mode;
        r_cnt <= 4'd0;
      end else if (r_state == RUN && !bus.abort && bus.step_done) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
  assign bus.current_state = r_state;
  assign bus.selector      = r_sel;
  assign bus.step_cnt      = r_cnt;
  assign bus.busy          = r_state == LOAD || r_state == RUN;
  assign bus.done          = r_state == DONE;
  assign bus.err           = r_state == ERROR;
endmodule

// File: tb/tb_state_sequencer.sv
// tb_state_sequencer: directed per-cycle vectors pushed to a scoreboard queue, checked by a separate monitor
module tb_state_sequencer;
  localparam int NS = 3;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  typedef struct packed {
    logic [3:0] st;
    logic [2:0] sel;
    logic [3:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  state_sequencer_if bus();
  state_sequencer #(.NUM_STEPS(NS), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string nm, input exp_t e);
    logic [13:0] a;
    logic [13:0] r;
    a = {bus.current_state, bus.selector, bus.step_cnt, bus.busy, bus.done, bus.err};
    r = {e.st, e.sel, e.cnt, e.st == 4'd1 || e.st == 4'd2, e.st == 4'd3, e.st == 4'd15};
    n_vec++;
    if (a !== r) begin
      n_bad++;
      $display("FAIL %s #%0d: got st=%0d sel=%0d cnt=%0d busy/done/err=%b, expected st=%0d sel=%0d cnt=%0d busy/done/err=%b",
               nm, n_vec, a[13:10], a[9:7], a[6:3], a[2:0], r[13:10], r[9:7], r[6:3], r[2:0]);
    end
  endtask
  task automatic cyc(input logic s, input logic [2:0] m, input logic sd, input logic ab, input logic cl,
                     input logic [3:0] st, input logic [2:0] sl, input logic [3:0] c);
    @(negedge clk);
    bus.start = s;
    bus.mode = m;
    bus.step_done = sd;
    bus.abort = ab;
    bus.clear = cl;
    q.push_back({st, sl, c});
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) chk("cycle", q.pop_front());
  end
  initial begin
    bus.start = 1'b0;
    bus.mode = 3'd0;
    bus.step_done = 1'b0;
    bus.abort = 1'b0;
    bus.clear = 1'b0;
    #2;
    chk("reset", {4'd0, 3'd0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.mode = 3'b101;
    q.push_back({4'd1, 3'd5, 4'd0});
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd5, 4'd0);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd5, 4'd0);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd5, 4'd1);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd5, 4'd1);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd5, 4'd2);
    cyc(0, 0, 1, 0, 0, 4'd3, 3'd5, 4'd3);
    cyc(0, 0, 0, 0, 0, 4'd0, 3'd5, 4'd3);
    cyc(0, 0, 0, 0, 0, 4'd0, 3'd5, 4'd3);
    cyc(1, 1, 0, 0, 0, 4'd1, 3'd1, 4'd0);
    cyc(1, 3, 0, 0, 0, 4'd2, 3'd1, 4'd0);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd1, 4'd1);
    cyc(1, 2, 1, 0, 0, 4'd2, 3'd1, 4'd2);
    cyc(0, 0, 1, 1, 0, 4'd0, 3'd1, 4'd2);
    cyc(0, 0, 0, 0, 0, 4'd0, 3'd1, 4'd2);
    cyc(1, 7, 0, 1, 0, 4'd1, 3'd7, 4'd0);
    cyc(0, 0, 0, 1, 0, 4'd0, 3'd7, 4'd0);
    cyc(0, 0, 0, 1, 1, 4'd0, 3'd7, 4'd0);
    cyc(1, 4, 0, 0, 0, 4'd1, 3'd4, 4'd0);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd4, 4'd0);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd4, 4'd1);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd4, 4'd2);
    cyc(0, 0, 1, 0, 0, 4'd3, 3'd4, 4'd3);
    cyc(0, 0, 1, 1, 0, 4'd0, 3'd4, 4'd3);
    cyc(1, 6, 0, 0, 0, 4'd1, 3'd6, 4'd0);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd6, 4'd0);
`ifdef SEQ_TIMEOUT_EN
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd6, 4'd0);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd6, 4'd0);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd6, 4'd1);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd6, 4'd1);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd6, 4'd1);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd6, 4'd1);
    cyc(0, 0, 0, 0, 0, 4'd15, 3'd6, 4'd1);
    cyc(1, 2, 0, 1, 0, 4'd15, 3'd6, 4'd1);
    cyc(0, 0, 0, 0, 1, 4'd0, 3'd6, 4'd1);
`else
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, i == 100, 4'd2, 3'd6, 4'd0);
    cyc(0, 0, 0, 1, 0, 4'd0, 3'd6, 4'd0);
`endif
    cyc(1, 3, 0, 0, 0, 4'd1, 3'd3, 4'd0);
    cyc(0, 0, 0, 0, 0, 4'd2, 3'd3, 4'd0);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd3, 4'd1);
    cyc(0, 0, 1, 0, 0, 4'd2, 3'd3, 4'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {4'd0, 3'd0, 4'd0});
    bus.step_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 4'd0, 3'd0, 4'd0);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STEPS, default 8, giving the steps per run; the legal range is 1..15.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum RUN cycles without step_done; the legal range is 1..255.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low, and the ports SHALL be named clk and rst_n.
REQ-004 clk  input  1  sole clock; all flops SHALL sample on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to begin a run; it SHALL be sampled only in IDLE.
REQ-007 mode  input  3  run mode; it SHALL be captured into selector on accepted start.
REQ-008 step_done  input  1  single-cycle pulse marking completion of the current step.
REQ-009 abort  input  1  request to cancel the run in progress.
REQ-010 clear  input  1  exit from ERROR.
REQ-011 current_state  output  4  registered state code, driving output_logic.current_state.
REQ-012 selector  output  3  registered latched mode, driving output_logic.selector.
REQ-013 step_cnt  output  4  number of steps completed in the current run.
REQ-014 busy  output  1  high in LOAD and RUN.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  high while in ERROR.

Function
REQ-017 The state codes SHALL be IDLE=4'd0, LOAD=4'd1, RUN=4'd2, DONE=4'd3 and ERROR=4'd15; all other codes SHALL be unreachable.
REQ-018 If an unreachable code is ever held, the next state SHALL be IDLE.
REQ-019 In IDLE, start=1 SHALL cause a transition to LOAD on the next edge, selector<=mode and step_cnt<=0 on the same edge.
REQ-020 In IDLE, start=0 SHALL leave the state in IDLE.
REQ-021 LOAD SHALL last exactly one cycle and then go to RUN, with the idle-cycle counter cleared to 0.
REQ-022 In RUN, step_done=1 SHALL increment step_cnt and clear the idle-cycle counter.
REQ-023 In RUN, step_done=1 when step_cnt==NUM_STEPS-1 SHALL move the block to DONE, so step_cnt shows NUM_STEPS in DONE.
REQ-024 In RUN, step_done=0 SHALL keep the block in RUN and increment the idle-cycle counter, which saturates at 255.
REQ-025 DONE SHALL last exactly one cycle, with done=1, and then go to IDLE.
REQ-026 step_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-027 abort=1 in LOAD or RUN SHALL move the block to IDLE on the next edge, with step_cnt holding its value and no done pulse.
REQ-028 abort SHALL take priority over step_done and over timeout.
REQ-029 abort SHALL be ignored in IDLE, DONE and ERROR.
REQ-030 start SHALL be ignored outside IDLE, and selector SHALL remain stable from LOAD through DONE.
REQ-031 start and abort asserted together in IDLE SHALL cause a transition to LOAD, because abort is ignored in IDLE.
REQ-032 busy, done and err SHALL be decoded from the registered state only, with no combinational path from any input to any output.
REQ-033 Latency SHALL be: start to busy, 1 cycle; final step_done to done, 1 cycle; done to IDLE, 1 cycle.

Reset
REQ-034 Assertion of rst_n=0 SHALL immediately force current_state=IDLE, selector=0, step_cnt=0, busy=0, done=0, err=0 and idle-cycle counter=0, in any state including mid-run.
REQ-035 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which rst_n=1.

Configuration
REQ-036 The macro SEQ_TIMEOUT_EN SHALL control the timeout feature.
REQ-037 With SEQ_TIMEOUT_EN defined, RUN with step_done=0 and idle-cycle counter==TIMEOUT-1 SHALL go to ERROR on that edge.
REQ-038 With SEQ_TIMEOUT_EN defined, ERROR SHALL hold err=1 and current_state=4'd15 until clear=1, which returns the block to IDLE on the next edge.
REQ-039 With SEQ_TIMEOUT_EN undefined, the idle-cycle counter and the ERROR state SHALL be absent, err SHALL be tied to 0, clear SHALL be ignored, and RUN SHALL wait indefinitely.

Verification
REQ-040 Reset mid-RUN with step_cnt=5 -> all outputs 0 and current_state=0 immediately, before the next clk edge.
REQ-041 With NUM_STEPS=3: start with mode=3'b101, then 3 step_done pulses -> current_state sequence 0,1,2,2..,3,0; selector=5 from LOAD through DONE; done high exactly 1 cycle; step_cnt=3 in DONE.
REQ-042 abort and step_done asserted together in RUN with step_cnt=2 -> IDLE next cycle, step_cnt=2, done stays 0.
REQ-043 With SEQ_TIMEOUT_EN defined and TIMEOUT=4: RUN with no step_done -> ERROR after 4 RUN cycles with err=1; clear=1 -> IDLE next cycle.
REQ-044 With SEQ_TIMEOUT_EN undefined: 300 RUN cycles with no step_done -> state stays at 4'd2 and err=0.
REQ-045 start pulsed during RUN with mode changed to 3'b010 -> selector unchanged and no restart.
